// File: rtl/imm_pkg.sv
// rtl/imm_pkg.sv - shared immediate formats, widths and the format/extend decode function
package imm_pkg;
    localparam int IMM_RAW_W = 26;
    localparam int SRC_W     = 4;
    localparam int RD_W      = 5;
    localparam logic [SRC_W-1:0] SRC_LOWER_ZX = 4'b1101;

    typedef enum logic [2:0] {BF, C, G, D, UPPER} imm_fmt_e;
    typedef enum logic {PASS, HOLD} state_e;

    function automatic imm_fmt_e imm_fmt(input logic [SRC_W-1:0] src);
        if (src[1]) return UPPER;
        case (src[3:2])
            2'b00:   return BF;
            2'b01:   return C;
            2'b10:   return G;
            default: return D;
        endcase
    endfunction

    // Result is built at 64 bits; callers truncate to their XLEN. The upper
    // field position depends on xlen, the sign-extended formats do not.
    function automatic logic [63:0] imm_decode(input logic [IMM_RAW_W-1:0] raw,
                                               input logic [SRC_W-1:0] src,
                                               input int xlen);
        logic        sign;
        logic [15:0] cf;
        logic [63:0] r;
        sign = src[0] ? 1'b0 : raw[25];
        cf   = {raw[25:15], raw[10:6]};
        case (imm_fmt(src))
            BF:      r = {{48{sign}}, raw[25:10]};
            C:       r = {{48{sign}}, cf};
            G:       r = {{46{sign}}, cf, 2'b00};
            D:       r = {{43{sign}}, raw[25:5]};
            default: r = (xlen == 64) ? {cf, 48'h0} : {32'h0, cf, 16'h0};
        endcase
        return r;
    endfunction
endpackage

// File: rtl/imm_out_fifo.sv
// rtl/imm_out_fifo.sv - small result FIFO with two write ports (push0 lands before push1)
module imm_out_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 38
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         push0,
    input  logic [W-1:0]                 data0,
    input  logic                         push1,
    input  logic [W-1:0]                 data1,
    input  logic                         pop,
    output logic [W-1:0]                 head,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr, wr_ptr1;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    assign wr_ptr1 = nxt(wr_ptr);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push0) mem[wr_ptr]  <= data0;
        if (push1) mem[wr_ptr1] <= data1;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push1)      wr_ptr <= nxt(wr_ptr1);
            else if (push0) wr_ptr <= wr_ptr1;
            if (pop)        rd_ptr <= nxt(rd_ptr);
            count <= count + CW'(push0) + CW'(push1) - CW'(pop);
        end
    end
endmodule

// File: rtl/imm_extend_pipe.sv
// rtl/imm_extend_pipe.sv - registered immediate extender with output FIFO; IMM_FUSE_EN enables upper+lower fusion
module imm_extend_pipe
    import imm_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int DEPTH    = 2,
    parameter int HOLD_MAX = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IMM_RAW_W-1:0] in_imm,
    input  logic [SRC_W-1:0]     in_src,
    input  logic [RD_W-1:0]      in_rd,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      out_imm,
    output logic [RD_W-1:0]      out_rd,
    output logic                 out_fused
);
    localparam int EW = XLEN + RD_W + 1;
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [CW-1:0]   count;
    logic [EW-1:0]   head, data0, data1;
    logic            push0, push1, pop, accept;
    logic [XLEN-1:0] dec;

    assign dec       = XLEN'(imm_decode(in_imm, in_src, XLEN));
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    assign accept    = in_valid && in_ready;
    // Outputs read as zero while empty so reset/flush leave a clean bus.
    assign {out_imm, out_rd, out_fused} = out_valid ? head : '0;

    imm_out_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push0 (push0),
        .data0 (data0),
        .push1 (push1),
        .data1 (data1),
        .pop   (pop),
        .head  (head),
        .count (count)
    );

`ifdef IMM_FUSE_EN
    localparam int TW = $clog2(HOLD_MAX+1);
    localparam logic [CW-1:0] ROOM2 = CW'(DEPTH-2);

    state_e          state, state_nxt;
    logic [XLEN-1:0] hold_imm, hold_imm_nxt;
    logic [RD_W-1:0] hold_rd, hold_rd_nxt;
    logic [TW-1:0]   timer, timer_nxt;
    logic            is_upper, is_lower;

    assign is_upper = in_src[1];
    assign is_lower = (in_src == SRC_LOWER_ZX);
    // HOLD may need two slots in one cycle, so it ignores the concurrent pop.
    assign in_ready = (state == PASS) ? (count < FULL || out_ready) : (count <= ROOM2);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state    <= PASS;
            hold_imm <= '0;
            hold_rd  <= '0;
            timer    <= '0;
        end else begin
            state    <= state_nxt;
            hold_imm <= hold_imm_nxt;
            hold_rd  <= hold_rd_nxt;
            timer    <= timer_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        hold_imm_nxt = hold_imm;
        hold_rd_nxt  = hold_rd;
        timer_nxt    = timer;
        push0        = 1'b0;
        push1        = 1'b0;
        data0        = {dec, in_rd, 1'b0};
        data1        = {dec, in_rd, 1'b0};
        case (state)
            PASS: begin
                if (accept && is_upper) begin
                    hold_imm_nxt = dec;
                    hold_rd_nxt  = in_rd;
                    timer_nxt    = '0;
                    state_nxt    = HOLD;
                end else if (accept) begin
                    push0 = 1'b1;
                end
            end
            default: begin
                if (accept) begin
                    timer_nxt = '0;
                    push0     = 1'b1;
                    if (is_lower && in_rd == hold_rd) begin
                        data0     = {hold_imm | dec, hold_rd, 1'b1};
                        state_nxt = PASS;
                    end else begin
                        data0 = {hold_imm, hold_rd, 1'b0};
                        if (is_upper) begin
                            hold_imm_nxt = dec;
                            hold_rd_nxt  = in_rd;
                        end else begin
                            push1     = 1'b1;
                            state_nxt = PASS;
                        end
                    end
                end else if (timer == TW'(HOLD_MAX)) begin
                    if (count < FULL || out_ready) begin
                        push0     = 1'b1;
                        data0     = {hold_imm, hold_rd, 1'b0};
                        timer_nxt = '0;
                        state_nxt = PASS;
                    end
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end
        endcase
    end
`else
    assign in_ready = (count < FULL) || out_ready;

    always_comb begin
        push0 = accept;
        push1 = 1'b0;
        data0 = {dec, in_rd, 1'b0};
        data1 = '0;
    end
`endif
endmodule

// File: tb/tb_imm_extend_pipe.sv
// tb/tb_imm_extend_pipe.sv - directed self-checking bench for imm_extend_pipe
module tb_imm_extend_pipe;
    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready, out_fused;
    logic [25:0] in_imm;
    logic [3:0]  in_src;
    logic [4:0]  in_rd, out_rd;
    logic [31:0] out_imm;
    int          vecs = 0;
    int          errs = 0;

    imm_extend_pipe #(.XLEN(32), .DEPTH(2), .HOLD_MAX(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_imm    (in_imm),
        .in_src    (in_src),
        .in_rd     (in_rd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_imm   (out_imm),
        .out_rd    (out_rd),
        .out_fused (out_fused)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [25:0] imm, input logic [3:0] src, input logic [4:0] rd);
        in_valid = 1'b1;
        in_imm   = imm;
        in_src   = src;
        in_rd    = rd;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_imm = '0; in_src = '0; in_rd = '0;
        tick(); tick();
        rst = 1'b0;
        vecs++;
        if ({out_valid, in_ready, out_fused, out_rd, out_imm} !== {1'b0, 1'b1, 1'b0, 5'd0, 32'h0}) begin
            errs++;
            $display("FAIL reset got v=%b r=%b f=%b rd=%0d imm=%h expected v=0 r=1 f=0 rd=0 imm=0",
                     out_valid, in_ready, out_fused, out_rd, out_imm);
        end
    endtask

    task automatic test_bf();
        out_ready = 1'b1;
        send(26'h2000400, 4'b0000, 5'd1);
        vecs++;
        if ({out_valid, out_fused, out_rd, out_imm} !== {1'b1, 1'b0, 5'd1, 32'hFFFF8001}) begin
            errs++;
            $display("FAIL bf_sign got v=%b rd=%0d imm=%h expected v=1 rd=1 imm=ffff8001", out_valid, out_rd, out_imm);
        end
        send(26'h2000400, 4'b0001, 5'd2);
        vecs++;
        if ({out_valid, out_fused, out_rd, out_imm} !== {1'b1, 1'b0, 5'd2, 32'h00008001}) begin
            errs++;
            $display("FAIL bf_zero got v=%b rd=%0d imm=%h expected v=1 rd=2 imm=00008001", out_valid, out_rd, out_imm);
        end
        tick();
        vecs++;
        if (out_valid !== 1'b0) begin
            errs++;
            $display("FAIL bf_drain got v=%b expected v=0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_src    = 4'b1000;
        for (int i = 0; i < 8; i++) begin
            in_imm = 26'(i) << 6;
            in_rd  = 5'(i + 8);
            exp    = 32'(i * 4);
            tick();
            vecs++;
            if ({out_valid, out_rd, out_imm} !== {1'b1, 5'(i + 8), exp}) begin
                errs++;
                $display("FAIL b2b_%0d got v=%b rd=%0d imm=%h expected v=1 rd=%0d imm=%h",
                         i, out_valid, out_rd, out_imm, i + 8, exp);
            end
        end
        in_valid = 1'b0;
        tick();
        vecs++;
        if (out_valid !== 1'b0) begin
            errs++;
            $display("FAIL b2b_drain got v=%b expected v=0", out_valid);
        end
    endtask

    task automatic test_fusion();
        out_ready = 1'b1;
        send(26'h0488500, 4'b0010, 5'd3);
`ifdef IMM_FUSE_EN
        vecs++;
        if (out_valid !== 1'b0) begin
            errs++;
            $display("FAIL fuse_held got v=%b expected v=0", out_valid);
        end
        send(26'h00ACF00, 4'b1101, 5'd3);
        vecs++;
        if ({out_valid, out_fused, out_rd, out_imm} !== {1'b1, 1'b1, 5'd3, 32'h12345678}) begin
            errs++;
            $display("FAIL fuse_pair got v=%b f=%b rd=%0d imm=%h expected v=1 f=1 rd=3 imm=12345678",
                     out_valid, out_fused, out_rd, out_imm);
        end
`else
        vecs++;
        if ({out_valid, out_fused, out_rd, out_imm} !== {1'b1, 1'b0, 5'd3, 32'h12340000}) begin
            errs++;
            $display("FAIL fuse_upper got v=%b f=%b rd=%0d imm=%h expected v=1 f=0 rd=3 imm=12340000",
                     out_valid, out_fused, out_rd, out_imm);
        end
        send(26'h00ACF00, 4'b1101, 5'd3);
        vecs++;
        if ({out_valid, out_fused, out_rd, out_imm} !== {1'b1, 1'b0, 5'd3, 32'h00005678}) begin
            errs++;
            $display("FAIL fuse_lower got v=%b f=%b rd=%0d imm=%h expected v=1 f=0 rd=3 imm=00005678",
                     out_valid, out_fused, out_rd, out_imm);
        end
`endif
        tick();
        vecs++;
        if (out_valid !== 1'b0) begin
            errs++;
            $display("FAIL fuse_drain got v=%b expected v=0", out_valid);
        end
    endtask

    task automatic test_mismatch();
        out_ready = 1'b1;
        send(26'h0488500, 4'b0010, 5'd3);
`ifdef IMM_FUSE_EN
        send(26'h00ACF00, 4'b1101, 5'd4);
`endif
        vecs++;
        if ({out_valid, out_fused, out_rd, out_imm} !== {1'b1, 1'b0, 5'd3, 32'h12340000}) begin
            errs++;
            $display("FAIL mism_upper got v=%b f=%b rd=%0d imm=%h expected v=1 f=0 rd=3 imm=12340000",
                     out_valid, out_fused, out_rd, out_imm);
        end
`ifdef IMM_FUSE_EN
        tick();
`else
        send(26'h00ACF00, 4'b1101, 5'd4);
`endif
        vecs++;
        if ({out_valid, out_fused, out_rd, out_imm} !== {1'b1, 1'b0, 5'd4, 32'h00005678}) begin
            errs++;
            $display("FAIL mism_lower got v=%b f=%b rd=%0d imm=%h expected v=1 f=0 rd=4 imm=00005678",
                     out_valid, out_fused, out_rd, out_imm);
        end
        tick();
        vecs++;
        if (out_valid !== 1'b0) begin
            errs++;
            $display("FAIL mism_drain got v=%b expected v=0", out_valid);
        end
    endtask

    task automatic test_timeout();
        out_ready = 1'b1;
        send(26'h0488500, 4'b0010, 5'd7);
`ifdef IMM_FUSE_EN
        for (int i = 0; i < 4; i++) begin
            tick();
            vecs++;
            if (out_valid !== 1'b0) begin
                errs++;
                $display("FAIL timeout_early_%0d got v=%b expected v=0", i, out_valid);
            end
        end
        tick();
`endif
        vecs++;
        if ({out_valid, out_fused, out_rd, out_imm} !== {1'b1, 1'b0, 5'd7, 32'h12340000}) begin
            errs++;
            $display("FAIL timeout_emit got v=%b f=%b rd=%0d imm=%h expected v=1 f=0 rd=7 imm=12340000",
                     out_valid, out_fused, out_rd, out_imm);
        end
        tick();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        send(26'h2000400, 4'b0001, 5'd1);
        send(26'h00000C0, 4'b1000, 5'd2);
        vecs++;
        if ({in_ready, out_valid, out_rd, out_imm} !== {1'b0, 1'b1, 5'd1, 32'h00008001}) begin
            errs++;
            $display("FAIL bp_full got r=%b v=%b rd=%0d imm=%h expected r=0 v=1 rd=1 imm=00008001",
                     in_ready, out_valid, out_rd, out_imm);
        end
        in_valid = 1'b1; in_imm = 26'h00ACF00; in_src = 4'b1101; in_rd = 5'd5;
        tick(); tick();
        vecs++;
        if ({in_ready, out_valid, out_rd, out_imm} !== {1'b0, 1'b1, 5'd1, 32'h00008001}) begin
            errs++;
            $display("FAIL bp_stable got r=%b v=%b rd=%0d imm=%h expected r=0 v=1 rd=1 imm=00008001",
                     in_ready, out_valid, out_rd, out_imm);
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        vecs++;
        if ({out_valid, out_rd, out_imm} !== {1'b1, 5'd2, 32'h0000000C}) begin
            errs++;
            $display("FAIL bp_drain1 got v=%b rd=%0d imm=%h expected v=1 rd=2 imm=0000000c", out_valid, out_rd, out_imm);
        end
        tick();
        vecs++;
        if ({out_valid, out_rd, out_imm} !== {1'b1, 5'd5, 32'h00005678}) begin
            errs++;
            $display("FAIL bp_drain2 got v=%b rd=%0d imm=%h expected v=1 rd=5 imm=00005678", out_valid, out_rd, out_imm);
        end
        tick();
        vecs++;
        if (out_valid !== 1'b0) begin
            errs++;
            $display("FAIL bp_empty got v=%b expected v=0", out_valid);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        send(26'h2000400, 4'b0000, 5'd1);
        send(26'h0488500, 4'b0010, 5'd3);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        vecs++;
        if ({out_valid, in_ready, out_imm} !== {1'b0, 1'b1, 32'h0}) begin
            errs++;
            $display("FAIL flush got v=%b r=%b imm=%h expected v=0 r=1 imm=0", out_valid, in_ready, out_imm);
        end
        out_ready = 1'b1;
        send(26'h00ACF00, 4'b1101, 5'd3);
        vecs++;
        if ({out_valid, out_fused, out_rd, out_imm} !== {1'b1, 1'b0, 5'd3, 32'h00005678}) begin
            errs++;
            $display("FAIL flush_lower got v=%b f=%b rd=%0d imm=%h expected v=1 f=0 rd=3 imm=00005678",
                     out_valid, out_fused, out_rd, out_imm);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_bf();
        test_back_to_back();
        test_fusion();
        test_mismatch();
        test_timeout();
        test_backpressure();
        test_flush();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
